// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
//   ST_*     : FSM state encodings (IDLE -> REQ -> WAIT -> IDLE)
//   wb_wr_t  : request payload latched from the winning master
//   wd_width : watchdog counter width for a given timeout
package wb_arb_pkg;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             we;
    logic [DAT_W-1:0] dat;
  } wb_wr_t;

  // Bits needed to count 0..timeout, never less than one.
  function automatic int unsigned wd_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_rr_arb_pick.sv
// Combinational two-way round-robin pick.
//   req : request vector, bit N = master N
//   ptr : priority pointer, 0 favours master 0, 1 favours master 1
//   gnt : one-hot winner, 00 when nobody requests
module wb_rr_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// One single-beat transfer per grant, priority alternates after each grant.
//   clk_i, rst_n_i         : clock, async active-low reset
//   mN_*_i / mN_*_o        : master N request in, ack/err/stall/read data out
//   s_*_o / s_*_i          : registered request to slave, slave response in
//   grant_o                : one-hot owner of the slave port, 00 when idle
//   timeout_o              : one-cycle pulse when the watchdog fires
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_we_i,
  input  logic [31:0]       m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  output logic [31:0]       m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_we_i,
  input  logic [31:0]       m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic [31:0]       m1_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic [31:0]       s_dat_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i,
  input  logic [31:0]       s_dat_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int unsigned WD_W = wd_width(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        grant_d;
  logic              s_cyc_d, s_stb_d;
  logic [ADDR_W-1:0] s_adr_d;
  wb_wr_t            pay_q, pay_d, pay0, pay1;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_d;
  logic [1:0]        to_gnt_q, to_gnt_d;

  logic [1:0] req;
  logic [1:0] cyc_v;
  logic [1:0] gnt_c;
  logic       owner_cyc;
  logic       slave_done;
  logic       wd_hit;

  assign req        = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign cyc_v      = {m1_cyc_i, m0_cyc_i};
  assign owner_cyc  = |(grant_o & cyc_v);
  assign slave_done = s_ack_i | s_err_i;
  // Fires on the last counted cycle so the err/timeout cycle lands TIMEOUT cycles after REQ entry.
  assign wd_hit     = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  assign pay0 = '{sel: m0_sel_i, we: m0_we_i, dat: m0_dat_i};
  assign pay1 = '{sel: m1_sel_i, we: m1_we_i, dat: m1_dat_i};

  wb_rr_arb_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_o;
    s_cyc_d   = s_cyc_o;
    s_stb_d   = s_stb_o;
    s_adr_d   = s_adr_o;
    pay_d     = pay_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    to_gnt_d  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // The timed-out master still holds stb during its err cycle; do not re-grant then.
        if ((gnt_c != 2'b00) && !timeout_o) begin
          state_d = ST_REQ;
          grant_d = gnt_c;
          s_cyc_d = 1'b1;
          s_stb_d = 1'b1;
          wd_d    = '0;
          s_adr_d = gnt_c[1] ? m1_adr_i : m0_adr_i;
          pay_d   = gnt_c[1] ? pay1 : pay0;
        end
      end
      ST_REQ, ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (!owner_cyc || slave_done || wd_hit) begin
          // Abort beats slave response, slave response beats the watchdog.
          state_d = ST_IDLE;
          grant_d = 2'b00;
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          ptr_d   = grant_o[0];
          if (owner_cyc && !slave_done) begin
            timeout_d = 1'b1;
            to_gnt_d  = grant_o;
          end
        end else if ((state_q == ST_REQ) && !s_stall_i) begin
          s_stb_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      grant_o   <= 2'b00;
      s_cyc_o   <= 1'b0;
      s_stb_o   <= 1'b0;
      s_adr_o   <= '0;
      pay_q     <= '0;
      wd_q      <= '0;
      timeout_o <= 1'b0;
      to_gnt_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_o   <= grant_d;
      s_cyc_o   <= s_cyc_d;
      s_stb_o   <= s_stb_d;
      s_adr_o   <= s_adr_d;
      pay_q     <= pay_d;
      wd_q      <= wd_d;
      timeout_o <= timeout_d;
      to_gnt_q  <= to_gnt_d;
    end
  end

  assign s_sel_o = pay_q.sel;
  assign s_we_o  = pay_q.we;
  assign s_dat_o = pay_q.dat;

  // Return path: slave response straight to the owner, watchdog err from the registered pulse.
  assign m0_ack_o   = s_ack_i & grant_o[0] & m0_cyc_i;
  assign m1_ack_o   = s_ack_i & grant_o[1] & m1_cyc_i;
  assign m0_err_o   = (s_err_i & grant_o[0] & m0_cyc_i) | (timeout_o & to_gnt_q[0]);
  assign m1_err_o   = (s_err_i & grant_o[1] & m1_cyc_i) | (timeout_o & to_gnt_q[1]);
  assign m0_dat_o   = grant_o[0] ? s_dat_i : 32'h0;
  assign m1_dat_o   = grant_o[1] ? s_dat_i : 32'h0;
  assign m0_stall_o = req[0] & ~(m0_ack_o | m0_err_o);
  assign m1_stall_o = req[1] & ~(m1_ack_o | m1_err_o);

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Bench for wb_rr_arbiter2: transaction-level reference model plus directed scenarios.
module tb_wb_rr_arbiter2;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned TO     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              m_cyc [2];
  logic              m_stb [2];
  logic [ADDR_W-1:0] m_adr [2];
  logic [3:0]        m_sel [2];
  logic              m_we  [2];
  logic [31:0]       m_dat [2];

  logic m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_rd, m1_rd;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_dat_o;
  logic [1:0] grant_o;
  logic s_ack = 1'b0, s_err = 1'b0, s_stall = 1'b0;
  logic [31:0] s_rdat = 32'h0;

  wb_rr_arbiter2 #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_dat_i(m_dat[0]), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_stall_o(m0_stall), .m0_dat_o(m0_rd),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_dat_i(m_dat[1]), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_stall_o(m1_stall), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_rdat), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial forever #5 clk = ~clk;

  // Stimulus mailboxes: main writes issued/abort_cnt/cfg_*, agents keep their own "seen" counters.
  int issued [2] = '{0, 0};
  int served [2] = '{0, 0};
  int abort_cnt [2] = '{0, 0};
  int abort_seen [2] = '{0, 0};
  int consumed [2] = '{0, 0};
  logic [ADDR_W-1:0] q_adr [2];
  logic              q_we  [2];
  logic [31:0]       q_dat [2];
  int cfg_stall = 0, cfg_ack_dly = 2, cfg_noack = 0, noack_used = 0;
  int force_cnt = 0, force_seen = 0;
  logic [31:0] cfg_rdat = 32'h0;

  // Observation counters, written only by the main process.
  int n_pass = 0, n_total = 0, cyc_n = 0;
  int ack_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic [31:0] last_rd [2];
  int glog [$];
  int gtime [$];
  int stb_run = 0, stb_len = 0, err_t = -1, to_t = -1;
  logic [1:0] prev_grant = 2'b00;

  // Reference model state: who owns the slave, whether the strobe is still pending, etc.
  int md_owner = -1, md_age = 0, md_ptr = 0, md_to_owner = 0;
  bit md_stb = 1'b0, md_to = 1'b0;
  logic [ADDR_W-1:0] md_adr = '0;
  logic [3:0] md_sel = '0;
  logic md_we = 1'b0;
  logic [31:0] md_dat = '0;

  // Master agents: hold cyc/stb until ack, err or a requested abort.
  initial begin
    for (int n = 0; n < 2; n++) begin
      m_cyc[n] = 0; m_stb[n] = 0; m_adr[n] = '0; m_sel[n] = '0; m_we[n] = 0; m_dat[n] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!rst_n) begin
          m_cyc[n] = 0; m_stb[n] = 0;
          served[n] = issued[n]; consumed[n] = done_cnt[n]; abort_seen[n] = abort_cnt[n];
        end else if (m_cyc[n]) begin
          if (done_cnt[n] != consumed[n] || abort_cnt[n] != abort_seen[n]) begin
            m_cyc[n] = 0; m_stb[n] = 0;
            consumed[n] = done_cnt[n]; abort_seen[n] = abort_cnt[n];
          end
        end else if (served[n] != issued[n]) begin
          served[n]++;
          m_cyc[n] = 1; m_stb[n] = 1;
          m_adr[n] = q_adr[n]; m_sel[n] = 4'hF; m_we[n] = q_we[n]; m_dat[n] = q_dat[n];
        end
      end
    end
  end

  // Slave responder: stall cfg_stall strobe cycles, ack cfg_ack_dly cycles after acceptance.
  initial begin
    int st_cnt, w_cnt;
    st_cnt = 0; w_cnt = 0;
    forever begin
      @(posedge clk); #1;
      s_ack = 0; s_err = 0; s_rdat = cfg_rdat;
      if (force_cnt != force_seen) begin s_ack = 1; force_seen = force_cnt; end
      if (!s_cyc_o) begin
        st_cnt = 0; w_cnt = 0; s_stall = 0;
      end else if (s_stb_o) begin
        w_cnt = 0;
        if (st_cnt < cfg_stall) begin s_stall = 1; st_cnt++; end else s_stall = 0;
      end else begin
        s_stall = 0; w_cnt++;
        if (w_cnt == cfg_ack_dly) begin
          if (noack_used < cfg_noack) noack_used++; else s_ack = 1;
        end
      end
    end
  end

  // Reference model: one transfer at a time, tie goes to md_ptr, owner's abort/response/age end it.
  initial forever begin
    bit was_to, r0, r1, fin;
    int win;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      md_owner = -1; md_stb = 0; md_age = 0; md_ptr = 0; md_to = 0; md_to_owner = 0;
      md_adr = '0; md_sel = '0; md_we = 0; md_dat = '0;
    end else begin
      was_to = md_to; md_to = 0; fin = 0;
      if (md_owner < 0) begin
        r0 = m_cyc[0] && m_stb[0];
        r1 = m_cyc[1] && m_stb[1];
        win = (r0 && r1) ? md_ptr : r0 ? 0 : r1 ? 1 : -1;
        if (!was_to && win >= 0) begin
          md_owner = win; md_stb = 1; md_age = 0;
          md_adr = m_adr[win]; md_sel = m_sel[win]; md_we = m_we[win]; md_dat = m_dat[win];
        end
      end else if (!m_cyc[md_owner] || s_ack || s_err) begin
        fin = 1;
      end else if (md_age + 1 == int'(TO)) begin
        md_to = 1; md_to_owner = md_owner; fin = 1;
      end else begin
        md_age++;
        if (md_stb && !s_stall) md_stb = 0;
      end
      if (fin) begin md_ptr = 1 - md_owner; md_owner = -1; md_stb = 0; end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    else n_pass++;
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc_n);
  endtask

  // One clock: compare every output against the model, then log events.
  task automatic tick();
    logic ack_a [2], err_a [2], stall_a [2];
    logic [31:0] rd_a [2];
    logic ea, ee;
    @(negedge clk);
    cyc_n++;
    ack_a = '{m0_ack, m1_ack}; err_a = '{m0_err, m1_err};
    stall_a = '{m0_stall, m1_stall}; rd_a = '{m0_rd, m1_rd};
    chk("grant", 64'(grant_o), md_owner < 0 ? 64'd0 : (md_owner == 0 ? 64'd1 : 64'd2));
    chk("s_cyc", 64'(s_cyc_o), 64'(md_owner >= 0));
    chk("s_stb", 64'(s_stb_o), 64'(md_owner >= 0 && md_stb));
    chk("timeout", 64'(timeout_o), 64'(md_to));
    chk("s_adr", 64'(s_adr_o), 64'(md_adr));
    chk("s_sel", 64'(s_sel_o), 64'(md_sel));
    chk("s_we", 64'(s_we_o), 64'(md_we));
    chk("s_dat", 64'(s_dat_o), 64'(md_dat));
    for (int n = 0; n < 2; n++) begin
      ea = (md_owner == n) && m_cyc[n] && s_ack;
      ee = ((md_owner == n) && m_cyc[n] && s_err) || (md_to && md_to_owner == n);
      chk($sformatf("m%0d_ack", n), 64'(ack_a[n]), 64'(ea));
      chk($sformatf("m%0d_err", n), 64'(err_a[n]), 64'(ee));
      chk($sformatf("m%0d_stall", n), 64'(stall_a[n]), 64'(m_cyc[n] && m_stb[n] && !(ea || ee)));
      chk($sformatf("m%0d_dat", n), 64'(rd_a[n]), (md_owner == n) ? 64'(s_rdat) : 64'd0);
      if (ack_a[n]) begin ack_cnt[n]++; done_cnt[n]++; last_rd[n] = rd_a[n]; end
      if (err_a[n]) begin err_cnt[n]++; done_cnt[n]++; err_t = cyc_n; end
    end
    if (grant_o != 2'b00 && prev_grant == 2'b00) begin
      glog.push_back(grant_o[1] ? 1 : 0);
      gtime.push_back(cyc_n);
    end
    prev_grant = grant_o;
    if (s_stb_o) stb_run++;
    else if (stb_run != 0) begin stb_len = stb_run; stb_run = 0; end
    if (timeout_o) to_t = cyc_n;
  endtask

  task automatic issue(input int n, input int cnt, input logic [ADDR_W-1:0] adr,
                       input logic we, input logic [31:0] dat);
    q_adr[n] = adr; q_we[n] = we; q_dat[n] = dat;
    issued[n] += cnt;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      tick();
      idle = issued[0] == served[0] && issued[1] == served[1] && !m_cyc[0] && !m_cyc[1]
             && !s_cyc_o && !timeout_o;
    end
    if (!idle) bound_fail(name);
  endtask

  task automatic wait_wait_phase(input string name, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = s_cyc_o && !s_stb_o;
    end
    if (!hit) bound_fail(name);
  endtask

  initial begin
    int base, a0, e1;
    // Reset state
    tick(); tick();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_dat", 64'(s_dat_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // m0 alone writes DEADBEEF to adr 1, ack two cycles after the strobe
    cfg_stall = 0; cfg_ack_dly = 2;
    issue(0, 1, 2'd1, 1'b1, 32'hDEADBEEF);
    run_until_idle("t1_idle", 40);
    chk("t1_acks", 64'(ack_cnt[0]), 64'd1);
    chk("t1_stb_len", 64'(stb_len), 64'd1);
    chk("t1_grant0", 64'(glog[0]), 64'd0);
    chk("t1_s_dat", 64'(s_dat_o), 64'hDEADBEEF);
    chk("t1_s_adr", 64'(s_adr_o), 64'd1);

    // Pointer now favours m1: simultaneous requests serve m1 first
    issue(0, 1, 2'd2, 1'b1, 32'h0000_00A0);
    issue(1, 1, 2'd3, 1'b1, 32'h0000_00B1);
    run_until_idle("t1b_idle", 60);
    chk("t1b_first", 64'(glog[1]), 64'd1);
    chk("t1b_second", 64'(glog[2]), 64'd0);

    // m1 read with three stall cycles
    cfg_stall = 3; cfg_ack_dly = 1; cfg_rdat = 32'h12345678;
    issue(1, 1, 2'd2, 1'b0, 32'h0);
    run_until_idle("t3_idle", 40);
    chk("t3_stb_len", 64'(stb_len), 64'd4);
    chk("t3_rdata", 64'(last_rd[1]), 64'h12345678);
    chk("t3_grant", 64'(glog[3]), 64'd1);

    // Four back-to-back pairs alternate starting with m0
    cfg_stall = 0; cfg_ack_dly = 2; cfg_rdat = 32'hCAFE0000;
    issue(0, 4, 2'd0, 1'b1, 32'h1111_0000);
    issue(1, 4, 2'd1, 1'b1, 32'h2222_0000);
    run_until_idle("t2_idle", 200);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_order%0d", i), 64'(glog[4 + i]), 64'(i % 2));

    // Watchdog: slave ignores m0, m1 served next
    base = glog.size();
    a0 = ack_cnt[1];
    cfg_noack = 1;
    issue(0, 1, 2'd3, 1'b1, 32'h5555_AAAA);
    issue(1, 1, 2'd0, 1'b1, 32'h6666_BBBB);
    run_until_idle("t4_idle", 80);
    chk("t4_err0", 64'(err_cnt[0]), 64'd1);
    chk("t4_to_delay", 64'(to_t - gtime[base]), 64'd8);
    chk("t4_err_with_to", 64'(err_t), 64'(to_t));
    chk("t4_order0", 64'(glog[base]), 64'd0);
    chk("t4_order1", 64'(glog[base + 1]), 64'd1);
    chk("t4_m1_ack", 64'(ack_cnt[1] - a0), 64'd1);

    // m1 aborts in WAIT; a late slave ack must not reach it
    a0 = ack_cnt[1]; e1 = err_cnt[1];
    cfg_ack_dly = 10;
    issue(1, 1, 2'd1, 1'b0, 32'h0);
    wait_wait_phase("t5_wait", 20);
    abort_cnt[1]++;
    tick(); tick();
    chk("t5_cyc_drop", 64'(s_cyc_o), 64'd0);
    force_cnt++;
    tick();
    chk("t5_late_ack_seen", 64'(s_ack), 64'd1);
    chk("t5_late_ack_blocked", 64'(m1_ack), 64'd0);
    run_until_idle("t5_idle", 20);
    chk("t5_no_ack", 64'(ack_cnt[1] - a0), 64'd0);
    chk("t5_no_err", 64'(err_cnt[1] - e1), 64'd0);

    // Async reset in the middle of WAIT, then a normal transfer
    a0 = ack_cnt[0];
    issue(0, 1, 2'd2, 1'b1, 32'h0BAD_F00D);
    wait_wait_phase("t6_wait", 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cyc", 64'(s_cyc_o), 64'd0);
    chk("t6_async_grant", 64'(grant_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("t6_no_ack_in_rst", 64'(ack_cnt[0] - a0), 64'd0);
    tick();
    cfg_ack_dly = 2;
    issue(0, 1, 2'd3, 1'b1, 32'hFEED_0001);
    run_until_idle("t6_idle", 40);
    chk("t6_ack_after", 64'(ack_cnt[0] - a0), 64'd1);
    chk("t6_s_dat", 64'(s_dat_o), 64'hFEED_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time: simulation time limit reached");
    $fatal(1);
  end

endmodule
